// File: rtl/cla_pipe_addsub_pkg.sv
// Shared definitions for the pipelined CLA adder/subtractor.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: mode encodings, ALU status flag bit positions, and the
// configuration legality check used by the top level at elaboration.
package cla_pipe_addsub_pkg;

  // Operation select on the 'sub' input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bit positions of the flags inside the ALU status register.
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;

  // A configuration is usable only when WIDTH splits evenly into STAGES
  // slices and each slice splits evenly into GROUP-bit lookahead groups.
  function automatic bit cfgLegal(input int width, input int stages, input int group);
    if (width < 1 || stages < 1 || group < 1) return 1'b0;
    if (width % stages != 0) return 1'b0;
    if ((width / stages) % group != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_slice.sv
// Combinational carry-lookahead adder for one pipeline slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: x, y (WIDTH operands), cin (carry in) -> s (WIDTH sum), cout (carry out).
module cla_slice #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NGRP = WIDTH / GROUP;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;      // carry into each bit
  logic [NGRP:0]    gc;     // carry into each group
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  gp;

  assign p = x ^ y;
  assign g = x & y;

  // Within a group every carry is a flat sum-of-products of the bit
  // generate/propagate terms and the group carry-in; groups are chained
  // through their group generate/propagate pair.
  always_comb begin
    logic term;
    logic acc;
    term = 1'b0;
    acc  = 1'b0;
    gg   = '0;
    gp   = '0;
    gc   = '0;
    c    = '0;
    gc[0] = cin;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[j*GROUP +: GROUP];
      for (int i = 0; i < GROUP; i++) begin
        term = g[j*GROUP + i];
        for (int m = i + 1; m < GROUP; m++) term = term & p[j*GROUP + m];
        gg[j] = gg[j] | term;
      end
      for (int i = 0; i < GROUP; i++) begin
        acc = gc[j];
        for (int m = 0; m < i; m++) acc = acc & p[j*GROUP + m];
        for (int k = 0; k < i; k++) begin
          term = g[j*GROUP + k];
          for (int m = k + 1; m < i; m++) term = term & p[j*GROUP + m];
          acc = acc | term;
        end
        c[j*GROUP + i] = acc;
      end
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
  end

  assign s    = p ^ c;
  assign cout = gc[NGRP];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES slice per stage.
// Latency: STAGES cycles from acceptance to outValid; one beat per cycle throughput.
// Backpressure: global stall; whole pipe holds while outValid && !outReady, inReady = !outValid || outReady.
// Ports: clk, rst (async active-low); inValid/inReady with a, b, carryInput, sub;
//        outValid/outReady with sum, carryOutput, overflow, zero, negative.
module cla_pipe_addsub
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryInput,
  input  logic             sub,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             carryOutput,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SLICE = WIDTH / STAGES;

  if (!cfgLegal(WIDTH, STAGES, GROUP)) begin : gBadCfg
    $error("cla_pipe_addsub: WIDTH must split into STAGES slices that are multiples of GROUP");
  end

  logic             adv;
  logic [WIDTH-1:0] bEff;
  logic             cin;
  logic [FLAG_W-1:0] flags;

  assign adv     = !outValid || outReady;
  assign inReady = adv;
  assign bEff    = (sub == MODE_SUB) ? ~b : b;
  assign cin     = (sub == MODE_ADD) ? carryInput : 1'b1;

  // Stage k adds slice k. Operand bits not yet consumed ride along in
  // aRemQ/bRemQ (lowest slice first); finished sum bits accumulate in sumQ.
  // Data registers only load for valid beats so bubbles leave them quiet.
  for (genvar k = 0; k < STAGES; k++) begin : gStage
    localparam int DONE = (k + 1) * SLICE;
    localparam int REM  = WIDTH - DONE;

    logic [SLICE-1:0] sliceX;
    logic [SLICE-1:0] sliceY;
    logic [SLICE-1:0] sliceS;
    logic             sliceC;
    logic             sliceCo;
    logic             inV;
    logic             inAMsb;
    logic             inBMsb;
    logic [DONE-1:0]  sumD;

    logic             vldQ;
    logic             cyQ;
    logic             aMsbQ;
    logic             bMsbQ;
    logic [DONE-1:0]  sumQ;

    if (k == 0) begin : gIn
      assign sliceX = a[SLICE-1:0];
      assign sliceY = bEff[SLICE-1:0];
      assign sliceC = cin;
      assign inV    = inValid;
      assign inAMsb = a[WIDTH-1];
      assign inBMsb = bEff[WIDTH-1];
      assign sumD   = sliceS;
    end else begin : gIn
      assign sliceX = gStage[k-1].gRem.aRemQ[SLICE-1:0];
      assign sliceY = gStage[k-1].gRem.bRemQ[SLICE-1:0];
      assign sliceC = gStage[k-1].cyQ;
      assign inV    = gStage[k-1].vldQ;
      assign inAMsb = gStage[k-1].aMsbQ;
      assign inBMsb = gStage[k-1].bMsbQ;
      assign sumD   = {sliceS, gStage[k-1].sumQ};
    end

    cla_slice #(
      .WIDTH (SLICE),
      .GROUP (GROUP)
    ) uSlice (
      .x    (sliceX),
      .y    (sliceY),
      .cin  (sliceC),
      .s    (sliceS),
      .cout (sliceCo)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vldQ  <= 1'b0;
        cyQ   <= 1'b0;
        aMsbQ <= 1'b0;
        bMsbQ <= 1'b0;
        sumQ  <= '0;
      end else if (adv) begin
        vldQ <= inV;
        if (inV) begin
          cyQ   <= sliceCo;
          aMsbQ <= inAMsb;
          bMsbQ <= inBMsb;
          sumQ  <= sumD;
        end
      end
    end

    if (REM > 0) begin : gRem
      logic [REM-1:0] aRemD;
      logic [REM-1:0] bRemD;
      logic [REM-1:0] aRemQ;
      logic [REM-1:0] bRemQ;

      if (k == 0) begin : gSrc
        assign aRemD = a[WIDTH-1:SLICE];
        assign bRemD = bEff[WIDTH-1:SLICE];
      end else begin : gSrc
        localparam int PREV = WIDTH - k * SLICE;
        assign aRemD = gStage[k-1].gRem.aRemQ[PREV-1:SLICE];
        assign bRemD = gStage[k-1].gRem.bRemQ[PREV-1:SLICE];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          aRemQ <= '0;
          bRemQ <= '0;
        end else if (adv && inV) begin
          aRemQ <= aRemD;
          bRemQ <= bRemD;
        end
      end
    end
  end

  // Flags come from the last stage. Zero is qualified with outValid so
  // every output reads 0 straight out of reset.
  assign outValid      = gStage[STAGES-1].vldQ;
  assign sum           = gStage[STAGES-1].sumQ;
  assign flags[FLAG_C] = gStage[STAGES-1].cyQ;
  assign flags[FLAG_V] = (gStage[STAGES-1].aMsbQ == gStage[STAGES-1].bMsbQ) &&
                         (sum[WIDTH-1] != gStage[STAGES-1].aMsbQ);
  assign flags[FLAG_Z] = outValid & ~|sum;
  assign flags[FLAG_N] = sum[WIDTH-1];

  assign carryOutput = flags[FLAG_C];
  assign overflow    = flags[FLAG_V];
  assign zero        = flags[FLAG_Z];
  assign negative    = flags[FLAG_N];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: scoreboard of golden a+/-b results plus directed cases.
// Latency: expects STAGES cycles when the consumer never stalls.
// Backpressure: exercises a consumer stall, async reset mid-flight and full-rate streaming.
module tb_cla_pipe_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int GROUP  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             carryInput = 1'b0;
  logic             sub = 1'b0;
  logic             outValid;
  logic             outReady = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carryOutput;
  logic             overflow;
  logic             zero;
  logic             negative;

  always #5 clk = ~clk;

  cla_pipe_addsub #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .GROUP  (GROUP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inValid     (inValid),
    .inReady     (inReady),
    .a           (a),
    .b           (b),
    .carryInput  (carryInput),
    .sub         (sub),
    .outValid    (outValid),
    .outReady    (outReady),
    .sum         (sum),
    .carryOutput (carryOutput),
    .overflow    (overflow),
    .zero        (zero),
    .negative    (negative)
  );

  // f = {C, V, Z, N}
  typedef struct packed {
    logic [31:0] sum;
    logic [3:0]  f;
    int          cyc;
    logic        lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] av;
    logic [31:0] bv;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs [10] = '{
    '{32'd414,        32'd1036,       1'b0, 1'b0, 32'd1450,       4'b0000},
    '{32'd65535,      32'd65535,      1'b0, 1'b0, 32'd131070,     4'b0000},
    '{32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 32'd0,          4'b1010},
    '{32'd5,          32'd7,          1'b0, 1'b1, 32'hFFFF_FFFE,  4'b0001},
    '{32'h8000_0000,  32'd1,          1'b0, 1'b1, 32'h7FFF_FFFF,  4'b1100},
    '{32'd10,         32'd20,         1'b1, 1'b0, 32'd31,         4'b0000},
    '{32'd10,         32'd3,          1'b0, 1'b1, 32'd7,          4'b1000},
    '{32'd0,          32'd0,          1'b1, 1'b1, 32'd0,          4'b1010},
    '{32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 32'h8000_0000,  4'b0101},
    '{32'h8000_0000,  32'h8000_0000,  1'b0, 1'b0, 32'd0,          4'b1110}
  };

  exp_t        sbq [$];
  logic [31:0] outLog [$];
  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  int          retired = 0;
  logic [35:0] lastOut = '0;
  logic        latCheck = 1'b1;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden model built from signed/unsigned arithmetic rather than bit tricks.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sb);
    exp_t        e;
    logic [32:0] ext;
    logic [32:0] uns;
    logic        c;
    e = '0;
    if (sb) begin
      ext = {av[31], av} - {bv[31], bv};
      c   = (av >= bv);
    end else begin
      ext = {av[31], av} + {bv[31], bv} + {32'd0, ci};
      uns = {1'b0, av} + {1'b0, bv} + {32'd0, ci};
      c   = uns[32];
    end
    e.sum = ext[31:0];
    e.f   = {c, ext[32] ^ ext[31], ext[31:0] == 32'd0, ext[31]};
    return e;
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: retire at the output first, then record any acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (outValid && outReady) begin
        if (sbq.size() == 0) begin
          checkVal("unexpected_output", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          checkVal("sb_sum", sum, e.sum);
          checkVal("sb_flags", {carryOutput, overflow, zero, negative}, e.f);
          if (e.lat) checkVal("sb_latency", cycle - e.cyc, STAGES);
        end
        lastOut = {carryOutput, overflow, zero, negative, sum};
        outLog.push_back(sum);
        retired++;
      end
      if (inValid && inReady) begin
        e     = model(a, b, carryInput, sub);
        e.cyc = cycle;
        e.lat = latCheck;
        sbq.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that took the beat.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
    logic acc;
    int   n;
    a = av; b = bv; carryInput = ci; sub = sb; inValid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) checkVal("send_timeout", acc, 1);
    inValid = 1'b0;
  endtask

  task automatic expectOut(input string tag, input int idx, input logic [31:0] s, input logic [3:0] f);
    int n;
    n = 0;
    while (retired < idx && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (retired < idx) checkVal({tag, "_timeout"}, retired, idx);
    checkVal({tag, "_sum"}, lastOut[31:0], s);
    checkVal({tag, "_flags"}, lastOut[35:32], f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [35:0] held;
    int          idx;
    int          startCyc;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_outValid", outValid, 0);
    checkVal("rst_sum", sum, 0);
    checkVal("rst_flags", {carryOutput, overflow, zero, negative}, 0);
    rst = 1'b1;
    #1;
    checkVal("rst_inReady", inReady, 1);
    @(posedge clk); #1;

    // Directed vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      idx = retired + 1;
      send(vecs[i].av, vecs[i].bv, vecs[i].ci, vecs[i].sb);
      expectOut($sformatf("vec%0d", i), idx, vecs[i].s, vecs[i].f);
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: outReady low for cycles 2-4 of a 4-beat stream
    outLog.delete();
    latCheck = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(i, i, 1'b0, 1'b0);
      end
      begin
        @(posedge clk); #1;
        outReady = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        held = {carryOutput, overflow, zero, negative, sum};
        checkVal("stall_outValid", outValid, 1);
        checkVal("stall_inReady_a", inReady, 0);
        checkVal("stall_sum", sum, 2);
        @(posedge clk); #1;
        @(negedge clk);
        checkVal("stall_hold", {carryOutput, overflow, zero, negative, sum}, held);
        checkVal("stall_inReady_b", inReady, 0);
        @(posedge clk); #1;
        outReady = 1'b1;
      end
    join
    repeat (STAGES + 3) @(posedge clk);
    #1;
    checkVal("bp_count", outLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < outLog.size()) checkVal($sformatf("bp_order%0d", i), outLog[i], 2 * (i + 1));
    end
    latCheck = 1'b1;

    // Asynchronous reset with two beats in flight
    send(32'd100, 32'd1, 1'b0, 1'b0);
    send(32'd200, 32'd2, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    checkVal("midrst_outValid", outValid, 0);
    checkVal("midrst_sum", sum, 0);
    checkVal("midrst_flags", {carryOutput, overflow, zero, negative}, 0);
    sbq.delete();
    outLog.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkVal("midrst_inReady", inReady, 1);
    @(posedge clk); #1;
    idx = retired + 1;
    send(32'd10, 32'd20, 1'b0, 1'b0);
    expectOut("post_rst", idx, 32'd30, 4'b0000);
    repeat (4) @(posedge clk);
    #1;
    checkVal("post_rst_no_stale", outLog.size(), 1);

    // Full-rate random stream
    outLog.delete();
    startCyc = cycle;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) ra = 32'hFFFF_FFFF;
      if (i % 10 == 5) rb = 32'h8000_0000;
      if (i % 17 == 3) rb = ra;
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    checkVal("tput_cycles", cycle - startCyc, 100);
    repeat (STAGES + 3) @(posedge clk);
    #1;
    checkVal("tput_count", outLog.size(), 100);
    checkVal("tput_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the miniRISC ALU and address path; successor to the fixed 32-bit combinational CLA.
- Splits a WIDTH-bit add/sub into STAGES slices, one slice per clock, with the inter-slice carry registered; operands skew through the pipe.
- Valid/ready handshake on both sides; produces carry, overflow, zero and negative flags with the result.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 2, pipeline depth and slice count; 1 means a single registered CLA. SLICE = WIDTH/STAGES.
- GROUP, 4, CLA lookahead group width inside a slice; SLICE must be a multiple of GROUP.

Ports:
- clk  in  1  Single clock; all state changes on the rising edge.
- rst  in  1  Asynchronous, active-low reset.
- inValid  in  1  Operand beat present.
- inReady  out  1  Block accepts a beat this cycle.
- a  in  WIDTH  Operand A.
- b  in  WIDTH  Operand B.
- carryInput  in  1  Carry-in for add; ignored when sub=1.
- sub  in  1  0 = a+b+carryInput; 1 = a-b, computed as a+~b+1.
- outValid  out  1  Result beat present.
- outReady  in  1  Consumer takes the result this cycle.
- sum  out  WIDTH  Result, modulo 2^WIDTH.
- carryOutput  out  1  Carry out of the MSB. For sub: 1 means no borrow.
- overflow  out  1  Signed overflow.
- zero  out  1  sum == 0.
- negative  out  1  sum[WIDTH-1].

Behaviour:
- Reset (rst=0, asynchronous): every valid bit, the stage carry registers and all outputs go to 0. inReady reads 1 once rst=1. In-flight beats are discarded; there is no partial output after reset.
- Advance enable: adv = !outValid || outReady. inReady = adv, purely combinational from outValid/outReady. The whole pipe moves together; this is a global stall, not per-stage.
- Accept: a beat is accepted when inValid && inReady. On acceptance:
  - Effective operand bEff = sub ? ~b : b.
  - Effective carry cin = sub ? 1 : carryInput.
- Stage k (0..STAGES-1):
  - On adv, adds slice k of a and bEff plus the carry registered by stage k-1 (stage 0 uses cin).
  - Registers the slice-k sum bits and the slice carry-out.
  - Carries forward the not-yet-consumed upper operand slices and the already-computed lower sum bits.
- Latency: exactly STAGES cycles from acceptance to outValid, when never stalled. Throughput is one beat per cycle.
- Stall: when outValid=1 and outReady=0, every register and every output holds its value.
  - Bubbles do not collapse; a stalled empty stage stays empty.
  - inReady=0, and input changes are ignored.
- Simultaneous outReady=1 with a new input: the output beat retires and the new beat is accepted in the same cycle.
- Flags are valid with outValid and derived from the final stage:
  - carryOutput = carry out of bit WIDTH-1.
  - overflow = (a[MSB] == bEff[MSB]) && (sum[MSB] != a[MSB]), using the MSBs carried with the beat.
  - zero = ~|sum.
  - negative = sum[MSB].
- Wrap-around: the sum is truncated to WIDTH bits, with no saturation.
- outValid=0: sum and flags are don't-care to consumers, but must not be X after reset.

Decomposition:
- Shared package/header:
  - Mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - Flag bit indices FLAG_C=0, FLAG_V=1, FLAG_Z=2, FLAG_N=3, for the ALU status register.
  - Parameter legality checks for WIDTH%STAGES and SLICE%GROUP.
- Sub-module cla_slice: combinational GROUP-based CLA of width SLICE with inputs x, y, cin and outputs s, cout; instantiated once per stage.
- The top level holds only the pipeline registers, the handshake and the flag logic.

Test Plan (WIDTH=32, STAGES=2, GROUP=4):
- Add, no stall: a=414, b=1036, sub=0, cin=0 -> 2 cycles later sum=1450, C=0, V=0, Z=0, N=0.
- Cross-slice carry: a=65535, b=65535 -> sum=131070, C=0. Then a=0xFFFFFFFF, b=1 -> sum=0, C=1, Z=1, V=0.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, C=0, N=1. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, V=1, C=1.
- Back-pressure: stream 4 beats (1+1, 2+2, 3+3, 4+4) with outReady=0 for cycles 2-4.
  - While stalled: inReady=0, outputs stable.
  - After release: results 2, 4, 6, 8 in order, with none lost or duplicated.
- Reset mid-flight: accept 2 beats, pull rst low asynchronously mid-cycle.
  - Immediately: outValid=0, all outputs 0.
  - After release: a fresh 10+20 yields 30 at latency 2, with no stale beat.
- Throughput: 100 random beats with outReady=1 -> one result per cycle, each matching a golden a±b model including all four flags.
